// File: rtl/map_pkg.sv
// Shared definitions for the lane mapper pair (transmit forward map and
// receive reverse map): FSM state type, default fill words and the per-byte
// bit permutations.
package map_pkg;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [31:0] TRAIN_WORD_DEF = 32'hA5A5_5A5A;
  localparam logic [31:0] IDLE_WORD_DEF  = 32'hBCBC_BCBC;

  // Forward permutation of one byte (transmit side).
  function automatic logic [7:0] fwd_map_byte(input logic [7:0] b);
    logic [7:0] o;
    o[7] = b[0];
    o[6] = b[4];
    o[5] = b[1];
    o[4] = b[5];
    o[3] = b[2];
    o[2] = b[6];
    o[1] = b[3];
    o[0] = b[7];
    return o;
  endfunction

  // Reverse permutation of one byte (receive side); exact inverse of fwd_map_byte.
  function automatic logic [7:0] rev_map_byte(input logic [7:0] b);
    logic [7:0] o;
    o[0] = b[7];
    o[4] = b[6];
    o[1] = b[5];
    o[5] = b[4];
    o[2] = b[3];
    o[6] = b[2];
    o[3] = b[1];
    o[7] = b[0];
    return o;
  endfunction

  function automatic logic [31:0] fwd_map(input logic [31:0] w);
    logic [31:0] o;
    for (int unsigned i = 0; i < 4; i++) begin
      o[i*8 +: 8] = fwd_map_byte(w[i*8 +: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] rev_map(input logic [31:0] w);
    logic [31:0] o;
    for (int unsigned i = 0; i < 4; i++) begin
      o[i*8 +: 8] = rev_map_byte(w[i*8 +: 8]);
    end
    return o;
  endfunction

endpackage

// File: rtl/map_tx_fifo.sv
// Small synchronous FIFO for host words. Writes are ignored when full and
// reads when empty; head word is presented combinationally on rdata.
module map_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/map_tx.sv
// Transmit lane mapper: buffers host words, emits one mapped word per clock
// (training, data or idle fill) to the 32-bit serializer.
// Optional statistics counters are built when MAP_TX_STATS_EN is defined.
module map_tx
  import map_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TRAIN_LEN  = 16,
  parameter logic [31:0] TRAIN_WORD = TRAIN_WORD_DEF,
  parameter logic [31:0] IDLE_WORD  = IDLE_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        bypass,
  input  logic        train_req,
  output logic [31:0] dout,
  output logic        dout_k,
  output logic        training
`ifdef MAP_TX_STATS_EN
  ,
  output logic [31:0] data_cnt,
  output logic [31:0] idle_cnt,
  output logic [15:0] ovf_cnt
`endif
);

  localparam logic [7:0] LAST_CNT = 8'(TRAIN_LEN - 1);

  state_t      state, state_nx;
  logic [7:0]  count, count_nx;
  logic        ready_en;
  logic        push, pop;
  logic        full, empty;
  logic [31:0] head;

  // Selection stage: word chosen by the FSM, mapped into dout on the next edge.
  // This stage gives the two-edge accept-to-output latency.
  logic [31:0] sel_word, sel_word_nx;
  logic        sel_k, sel_k_nx;
  logic        sel_train, sel_train_nx;
  logic        sel_idle, sel_idle_nx;
  logic        mode_q, mode_nx;

  assign din_ready = ready_en && !full;
  assign push      = din_valid && din_ready;

  map_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (din),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Host-side acceptance is held off until the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // FSM state and training counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TRAIN;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Next-state logic and word selection (training, FIFO head or idle).
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    pop          = 1'b0;
    sel_word_nx  = IDLE_WORD;
    sel_k_nx     = 1'b1;
    sel_train_nx = 1'b0;
    sel_idle_nx  = 1'b0;
    case (state)
      TRAIN: begin
        sel_word_nx  = TRAIN_WORD;
        sel_train_nx = 1'b1;
        if (train_req) begin
          count_nx = '0;
        end else if (count == LAST_CNT) begin
          state_nx = RUN;
          count_nx = '0;
        end else begin
          count_nx = count + 8'd1;
        end
      end
      RUN: begin
        if (train_req) begin
          // Leaving RUN: hold the FIFO and send fill so queued data follows training.
          state_nx    = TRAIN;
          count_nx    = '0;
          sel_idle_nx = 1'b1;
        end else if (!empty) begin
          pop         = 1'b1;
          sel_word_nx = head;
          sel_k_nx    = 1'b0;
        end else begin
          sel_idle_nx = 1'b1;
        end
      end
      default: begin
        state_nx = TRAIN;
        count_nx = '0;
      end
    endcase
  end

  // Selection stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_word  <= '0;
      sel_k     <= 1'b1;
      sel_train <= 1'b1;
      sel_idle  <= 1'b0;
    end else begin
      sel_word  <= sel_word_nx;
      sel_k     <= sel_k_nx;
      sel_train <= sel_train_nx;
      sel_idle  <= sel_idle_nx;
    end
  end

  // Mode only follows bypass on fill words, so data bursts never change mode.
  always_comb begin
    mode_nx = sel_k ? bypass : mode_q;
  end

  // Output register: apply the mapper in the selected mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_k   <= 1'b1;
      training <= 1'b1;
      mode_q   <= 1'b0;
    end else begin
      dout     <= mode_nx ? sel_word : fwd_map(sel_word);
      dout_k   <= sel_k;
      training <= sel_train;
      mode_q   <= mode_nx;
    end
  end

`ifdef MAP_TX_STATS_EN
  // Saturating statistics; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_cnt <= '0;
      idle_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (!sel_k && (data_cnt != '1)) begin
        data_cnt <= data_cnt + 32'd1;
      end
      if (sel_idle && (idle_cnt != '1)) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if (din_valid && !din_ready && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_map_tx.sv
// Directed testbench for map_tx (default build, statistics disabled).
module tb_map_tx;
  import map_pkg::*;

  localparam logic [31:0] TRN_M  = 32'h9999_6666; // forward map of A5A55A5A
  localparam logic [31:0] IDL_M  = 32'h5B5B_5B5B; // forward map of BCBCBCBC
  localparam logic [31:0] IDL_R  = 32'hBCBC_BCBC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        bypass;
  logic        train_req;
  logic [31:0] dout;
  logic        dout_k;
  logic        training;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] w_in  [5];
  logic [31:0] w_out [5];

  map_tx #(
    .FIFO_DEPTH (4),
    .TRAIN_LEN  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bypass    (bypass),
    .train_req (train_req),
    .dout      (dout),
    .dout_k    (dout_k),
    .training  (training)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then the full training sequence followed by idle fill.
  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 1'b0; bypass = 1'b0; train_req = 1'b0;
    step(); step();
    vectors++;
    if (dout !== 32'h0 || dout_k !== 1'b1 || training !== 1'b1 || din_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got dout=%h k=%b trn=%b rdy=%b expected 00000000 1 1 0",
               dout, dout_k, training, din_ready);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 1", din_ready);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      vectors++;
      if (dout !== TRN_M || dout_k !== 1'b1 || training !== 1'b1) begin
        miscompares++;
        $display("FAIL train_word[%0d]: got %h k=%b trn=%b expected %h 1 1",
                 i, dout, dout_k, training, TRN_M);
      end
    end
    step();
    vectors++;
    if (dout !== IDL_M || dout_k !== 1'b1 || training !== 1'b0) begin
      miscompares++;
      $display("FAIL first_idle: got %h k=%b trn=%b expected %h 1 0", dout, dout_k, training, IDL_M);
    end
  endtask

  // Forward map values, two-edge latency and back-to-back throughput.
  task automatic test_map();
    din = 32'h1234_5678; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    vectors++;
    if (dout !== IDL_M || dout_k !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_n1: got %h k=%b expected %h 1", dout, dout_k, IDL_M);
    end
    step();
    vectors++;
    if (dout !== 32'h6058_6C56 || dout_k !== 1'b0) begin
      miscompares++;
      $display("FAIL map_12345678: got %h k=%b expected 60586c56 0", dout, dout_k);
    end
    vectors++;
    if (rev_map(dout) !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL rev_map: got %h expected 12345678", rev_map(dout));
    end
    din = 32'h0101_0101; din_valid = 1'b1;
    step();
    din = 32'h8080_8080;
    step();
    din_valid = 1'b0;
    step();
    vectors++;
    if (dout !== 32'h8080_8080 || dout_k !== 1'b0) begin
      miscompares++;
      $display("FAIL map_01010101: got %h k=%b expected 80808080 0", dout, dout_k);
    end
    step();
    vectors++;
    if (dout !== 32'h0101_0101 || dout_k !== 1'b0) begin
      miscompares++;
      $display("FAIL map_80808080: got %h k=%b expected 01010101 0", dout, dout_k);
    end
    step();
    vectors++;
    if (dout !== IDL_M || dout_k !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_burst: got %h k=%b expected %h 1", dout, dout_k, IDL_M);
    end
  endtask

  // train_req with 3 words queued: exactly 16 training words, then data, then idle.
  task automatic test_train_req();
    int n;
    din = w_in[0]; din_valid = 1'b1; train_req = 1'b1;
    step();
    train_req = 1'b0;
    din = w_in[1];
    step();
    din = w_in[2];
    step();
    din_valid = 1'b0;
    n = 0;
    while (training === 1'b1 && n < 40) begin
      if (dout !== TRN_M) begin
        vectors++;
        miscompares++;
        $display("FAIL retrain_word: got %h expected %h", dout, TRN_M);
      end
      n++;
      step();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL retrain_len: got %0d expected 16", n);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dout !== w_out[i] || dout_k !== 1'b0) begin
        miscompares++;
        $display("FAIL queued_word[%0d]: got %h k=%b expected %h 0", i, dout, dout_k, w_out[i]);
      end
      step();
    end
    vectors++;
    if (dout !== IDL_M || dout_k !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_retrain: got %h k=%b expected %h 1", dout, dout_k, IDL_M);
    end
  endtask

  // Bypass toggled mid-burst: burst keeps mapping, first fill word switches.
  task automatic test_bypass_switch();
    int n;
    bypass = 1'b0;
    din = w_in[0]; din_valid = 1'b1; train_req = 1'b1;
    step();
    train_req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      din = w_in[i];
      step();
    end
    din_valid = 1'b0;
    n = 0;
    while (dout_k !== 1'b0 && n < 40) begin
      n++;
      step();
    end
    vectors++;
    if (n >= 40) begin
      miscompares++;
      $display("FAIL bypass_burst_timeout: got no data in %0d cycles expected data", n);
    end
    bypass = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dout !== w_out[i] || dout_k !== 1'b0) begin
        miscompares++;
        $display("FAIL burst_mode[%0d]: got %h k=%b expected %h 0", i, dout, dout_k, w_out[i]);
      end
      step();
    end
    vectors++;
    if (dout !== IDL_R || dout_k !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_idle: got %h k=%b expected %h 1", dout, dout_k, IDL_R);
    end
    din = 32'h1234_5678; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step();
    vectors++;
    if (dout !== 32'h1234_5678 || dout_k !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_data: got %h k=%b expected 12345678 0", dout, dout_k);
    end
    bypass = 1'b0;
    step();
    vectors++;
    if (dout !== IDL_M || dout_k !== 1'b1) begin
      miscompares++;
      $display("FAIL unbypass_idle: got %h k=%b expected %h 1", dout, dout_k, IDL_M);
    end
  endtask

  // Fill the FIFO during training; fifth word is held until space frees up.
  task automatic test_backpressure();
    int n;
    rst = 1'b1; din_valid = 1'b0; bypass = 1'b0; train_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (din_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL ready_fill[%0d]: got %b expected 1", i, din_ready);
      end
      din = w_in[i]; din_valid = 1'b1;
      step();
    end
    din = w_in[4];
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (din_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_full[%0d]: got %b expected 0", i, din_ready);
      end
      step();
    end
    n = 0;
    while (din_ready !== 1'b1 && n < 40) begin
      n++;
      step();
    end
    vectors++;
    if (n >= 40) begin
      miscompares++;
      $display("FAIL ready_return_timeout: got ready=0 for %0d cycles expected 1", n);
    end
    step();
    din_valid = 1'b0;
    n = 0;
    while (dout_k !== 1'b0 && n < 40) begin
      n++;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dout !== w_out[i] || dout_k !== 1'b0) begin
        miscompares++;
        $display("FAIL order[%0d]: got %h k=%b expected %h 0", i, dout, dout_k, w_out[i]);
      end
      step();
    end
    vectors++;
    if (dout !== IDL_M || dout_k !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_drain: got %h k=%b expected %h 1", dout, dout_k, IDL_M);
    end
  endtask

  // Reset with 2 words queued: they are discarded and training restarts.
  task automatic test_mid_reset();
    int n;
    din = w_in[0]; din_valid = 1'b1; train_req = 1'b1;
    step();
    train_req = 1'b0;
    din = w_in[1];
    step();
    din_valid = 1'b0;
    rst = 1'b1;
    step();
    vectors++;
    if (dout !== 32'h0 || dout_k !== 1'b1 || training !== 1'b1 || din_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_state: got dout=%h k=%b trn=%b rdy=%b expected 00000000 1 1 0",
               dout, dout_k, training, din_ready);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (training === 1'b1 && dout === TRN_M) n++;
      vectors++;
      if (dout_k !== 1'b1) begin
        miscompares++;
        $display("FAIL discarded_word[%0d]: got %h k=%b expected k=1", i, dout, dout_k);
      end
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL mid_reset_retrain: got %0d training words expected 16", n);
    end
    vectors++;
    if (dout !== IDL_M) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got %h expected %h", dout, IDL_M);
    end
  endtask

  initial begin
    w_in[0] = 32'h1234_5678; w_out[0] = 32'h6058_6C56;
    w_in[1] = 32'h0101_0101; w_out[1] = 32'h8080_8080;
    w_in[2] = 32'h8080_8080; w_out[2] = 32'h0101_0101;
    w_in[3] = 32'hA5A5_5A5A; w_out[3] = 32'h9999_6666;
    w_in[4] = 32'hBCBC_BCBC; w_out[4] = 32'h5B5B_5B5B;
    test_reset();
    test_map();
    test_train_req();
    test_bypass_switch();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
